// File: rtl/sprite_flash_pkg.sv
// Shared types and constants for the sprite flash fetch path.
// SPRITE_FLASH_PREFETCH_EN adds the PREFETCH state.
package sprite_flash_pkg;

    localparam int unsigned FL_ADDR_W = 23;
    localparam int unsigned FL_DATA_W = 8;

    // Chroma key shared with the compositor.
    localparam logic [7:0] GREEN_BG = 8'h1C;

`ifdef SPRITE_FLASH_PREFETCH_EN
    typedef enum logic [1:0] {StIdle, StRead, StPrefetch} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRead} state_e;
`endif

endpackage

// File: rtl/flash_read_cycle.sv
// One timed asynchronous NOR read: holds the address and enables for WAIT_CYCLES
// cycles and strobes o_done in the cycle the data pins should be captured.
module flash_read_cycle
    import sprite_flash_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_W      = FL_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_fl_addr,
    output logic              o_fl_ce_n,
    output logic              o_fl_oe_n,
    output logic              o_done
);

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    logic              active_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;

    // A start overrides completion so a follow-on read keeps the enables low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
        end else if (i_start) begin
            active_q <= 1'b1;
            cnt_q    <= CntLoad;
            addr_q   <= i_addr;
        end else if (active_q) begin
            if (cnt_q == 4'd0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign o_done    = active_q && (cnt_q == 4'd0);
    assign o_fl_ce_n = ~active_q;
    assign o_fl_oe_n = ~active_q;
    assign o_fl_addr = addr_q;

endmodule

// File: rtl/sprite_flash_reader.sv
// Sprite pixel fetch responder: one-entry last-read cache in front of timed NOR reads.
// Define SPRITE_FLASH_PREFETCH_EN for the sequential prefetch buffer.
module sprite_flash_reader
    import sprite_flash_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_W      = FL_ADDR_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 o_ack,
    output logic [FL_DATA_W-1:0] o_data,
    output logic                 o_busy,
    output logic [ADDR_W-1:0]    o_fl_addr,
    output logic                 o_fl_ce_n,
    output logic                 o_fl_oe_n,
    output logic                 o_fl_we_n,
    output logic                 o_fl_rst_n,
    input  logic [FL_DATA_W-1:0] i_fl_dq
);

    state_e               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [FL_DATA_W-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]    cache_addr_q, cache_addr_d;
    logic [FL_DATA_W-1:0] cache_data_q, cache_data_d;
    logic                 rd_start, rd_done;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 hit_cache, hit_pf;

`ifdef SPRITE_FLASH_PREFETCH_EN
    logic                 pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0]    pf_addr_q, pf_addr_d;
    logic [FL_DATA_W-1:0] pf_data_q, pf_data_d;

    assign hit_pf = pf_valid_q && (i_addr == pf_addr_q);
`else
    assign hit_pf = 1'b0;
`endif

    assign hit_cache = cache_valid_q && (i_addr == cache_addr_q);

    flash_read_cycle #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .ADDR_W     (ADDR_W)
    ) u_cycle (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (rd_start),
        .i_addr   (rd_addr),
        .o_fl_addr(o_fl_addr),
        .o_fl_ce_n(o_fl_ce_n),
        .o_fl_oe_n(o_fl_oe_n),
        .o_done   (rd_done)
    );

    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        data_d        = data_q;
        busy_d        = busy_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        rd_start      = 1'b0;
        rd_addr       = i_addr;
`ifdef SPRITE_FLASH_PREFETCH_EN
        pf_valid_d    = pf_valid_q;
        pf_addr_d     = pf_addr_q;
        pf_data_d     = pf_data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    if (hit_cache) begin
                        ack_d  = 1'b1;
                        data_d = cache_data_q;
`ifdef SPRITE_FLASH_PREFETCH_EN
                    end else if (hit_pf) begin
                        ack_d  = 1'b1;
                        data_d = pf_data_q;
`endif
                    end else begin
                        rd_start = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = StRead;
                    end
                end
            end
            StRead: begin
                if (rd_done) begin
                    ack_d         = 1'b1;
                    data_d        = i_fl_dq;
                    busy_d        = 1'b0;
                    cache_valid_d = 1'b1;
                    cache_addr_d  = o_fl_addr;
                    cache_data_d  = i_fl_dq;
`ifdef SPRITE_FLASH_PREFETCH_EN
                    rd_start      = 1'b1;
                    rd_addr       = o_fl_addr + ADDR_W'(1);
                    state_d       = StPrefetch;
`else
                    state_d       = StIdle;
`endif
                end
            end
`ifdef SPRITE_FLASH_PREFETCH_EN
            StPrefetch: begin
                if (rd_done) begin
                    pf_valid_d = 1'b1;
                    pf_addr_d  = o_fl_addr;
                    pf_data_d  = i_fl_dq;
                    state_d    = StIdle;
                end
                if (i_req) begin
                    if (hit_cache) begin
                        ack_d  = 1'b1;
                        data_d = cache_data_q;
                    end else if (hit_pf) begin
                        ack_d  = 1'b1;
                        data_d = pf_data_q;
                    end else if (i_addr == o_fl_addr) begin
                        // Join the in-flight prefetch instead of restarting it.
                        if (rd_done) begin
                            ack_d  = 1'b1;
                            data_d = i_fl_dq;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = StRead;
                        end
                    end else begin
                        rd_start = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = StRead;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            ack_q         <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
`ifdef SPRITE_FLASH_PREFETCH_EN
            pf_valid_q    <= 1'b0;
            pf_addr_q     <= '0;
            pf_data_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
`ifdef SPRITE_FLASH_PREFETCH_EN
            pf_valid_q    <= pf_valid_d;
            pf_addr_q     <= pf_addr_d;
            pf_data_q     <= pf_data_d;
`endif
        end
    end

    assign o_ack      = ack_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_fl_we_n  = 1'b1;
    assign o_fl_rst_n = ~i_rst;

endmodule

// File: tb/tb_sprite_flash_reader.sv
// Directed bench for sprite_flash_reader with a combinational NOR flash model.
// Prefetch cases run only when SPRITE_FLASH_PREFETCH_EN is defined.
module tb_sprite_flash_reader;

    logic        clk;
    logic        rst;
    logic        req;
    logic [22:0] addr;
    logic        ack;
    logic [7:0]  data;
    logic        busy;
    logic [22:0] fl_addr;
    logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n;
    logic [7:0]  fl_dq;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_flash_reader #(
        .WAIT_CYCLES(5),
        .ADDR_W     (23)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_addr    (addr),
        .o_ack     (ack),
        .o_data    (data),
        .o_busy    (busy),
        .o_fl_addr (fl_addr),
        .o_fl_ce_n (fl_ce_n),
        .o_fl_oe_n (fl_oe_n),
        .o_fl_we_n (fl_we_n),
        .o_fl_rst_n(fl_rst_n),
        .i_fl_dq   (fl_dq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Flash contents: 0xE3 at 0x000100, otherwise an xor of the address bytes with 0x3C.
    function automatic logic [7:0] flash_byte(input logic [22:0] a);
        if (a == 23'h000100) return 8'hE3;
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
    endfunction

    always_comb fl_dq = fl_oe_n ? 8'h00 : flash_byte(fl_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its ack; leaves the bench in the ack cycle.
    task automatic do_req(input logic [22:0] a, input bit drop, output int lat,
                          output logic [7:0] d, output int ce_low, output logic busy1,
                          output logic [22:0] addr3);
        req  = 1'b1;
        addr = a;
        tick();
        req    = 1'b0;
        lat    = -1;
        d      = 8'h00;
        ce_low = 0;
        busy1  = busy;
        addr3  = fl_addr;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) addr3 = fl_addr;
            if (ack) begin
                lat = c;
                d   = data;
                break;
            end
            if (!fl_ce_n) ce_low++;
            if (drop && c == 2) begin
                req  = 1'b1;
                addr = 23'h000777;
            end
            tick();
            req = 1'b0;
        end
    endtask

    task automatic count_acks(input int n, output int k);
        k = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ack) k++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int          lat, ce_low, k;
        logic [7:0]  d;
        logic        b1;
        logic [22:0] a3;

        rst  = 1'b1;
        req  = 1'b0;
        addr = '0;
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_fl_addr", fl_addr, 0);
        check("rst_ce_n", fl_ce_n, 1);
        check("rst_oe_n", fl_oe_n, 1);
        check("rst_we_n", fl_we_n, 1);
        check("rst_fl_rst_n", fl_rst_n, 0);
        rst = 1'b0;
        tick();
        check("run_fl_rst_n", fl_rst_n, 1);

        // Cold miss.
        do_req(23'h000100, 1'b0, lat, d, ce_low, b1, a3);
        check("miss_lat", lat, 6);
        check("miss_data", d, 8'hE3);
        check("miss_ce_low", ce_low, 5);
        check("miss_busy", b1, 1);
        check("miss_busy_ack", busy, 0);
        tick();
        check("miss_single_ack", ack, 0);
`ifndef SPRITE_FLASH_PREFETCH_EN
        check("miss_ce_release", fl_ce_n, 1);
`endif

        // Cache hit.
        do_req(23'h000100, 1'b0, lat, d, ce_low, b1, a3);
        check("hit_lat", lat, 1);
        check("hit_data", d, 8'hE3);
        check("hit_busy", b1, 0);
`ifndef SPRITE_FLASH_PREFETCH_EN
        check("hit_ce_n", fl_ce_n, 1);
`endif
        idle(8);

        // Request dropped while busy.
        do_req(23'h123456, 1'b1, lat, d, ce_low, b1, a3);
        check("drop_lat", lat, 6);
        check("drop_data", d, 8'h4C);
        check("drop_fl_addr", a3, 23'h123456);
        count_acks(10, k);
        check("drop_no_extra_ack", k, 0);

        // Back-to-back misses, second issued in the first's ack cycle.
        do_req(23'h000200, 1'b0, lat, d, ce_low, b1, a3);
        check("b2b_a_lat", lat, 6);
        check("b2b_a_data", d, 8'h3E);
        do_req(23'h000500, 1'b0, lat, d, ce_low, b1, a3);
        check("b2b_b_lat", lat, 6);
        check("b2b_b_data", d, 8'h39);
        idle(8);

`ifdef SPRITE_FLASH_PREFETCH_EN
        // Prefetch wraps past the top address.
        do_req(23'h7FFFFF, 1'b0, lat, d, ce_low, b1, a3);
        check("wrap_miss_lat", lat, 6);
        check("wrap_miss_data", d, 8'h43);
        check("wrap_pf_addr", fl_addr, 23'h000000);
        idle(8);
        do_req(23'h000000, 1'b0, lat, d, ce_low, b1, a3);
        check("pf_hit_lat", lat, 1);
        check("pf_hit_data", d, 8'h3C);

        // Abort a prefetch for an unrelated address.
        do_req(23'h000200, 1'b0, lat, d, ce_low, b1, a3);
        check("abort_miss_lat", lat, 6);
        tick();
        tick();
        check("abort_pf_addr", fl_addr, 23'h000201);
        do_req(23'h000500, 1'b0, lat, d, ce_low, b1, a3);
        check("abort_lat", lat, 6);
        check("abort_data", d, 8'h39);
        idle(8);

        // Join an in-flight prefetch.
        do_req(23'h000300, 1'b0, lat, d, ce_low, b1, a3);
        check("join_miss_data", d, 8'h3F);
        tick();
        tick();
        do_req(23'h000301, 1'b0, lat, d, ce_low, b1, a3);
        check("join_lat", lat, 3);
        check("join_data", d, 8'h3E);
        check("join_busy", b1, 1);
        idle(8);
`endif

        // Reset in the middle of a demand read.
        req  = 1'b1;
        addr = 23'h000400;
        tick();
        req = 1'b0;
        check("abort_rd_busy", busy, 1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ack", ack, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fl_addr", fl_addr, 0);
        check("mid_rst_ce_n", fl_ce_n, 1);
        check("mid_rst_oe_n", fl_oe_n, 1);
        check("mid_rst_fl_rst_n", fl_rst_n, 0);
        rst = 1'b0;
        count_acks(10, k);
        check("mid_rst_no_ack", k, 0);
        do_req(23'h000500, 1'b0, lat, d, ce_low, b1, a3);
        check("post_rst_lat", lat, 6);
        check("post_rst_data", d, 8'h39);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
